// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: bundle between the two CPU bus masters, the arbiter and the bus bridge.
// slave = arbiter view (master commands and bus status in; grants, completions and bus command out); master = the opposite view.
interface ahb_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_we;
    logic [3:0]  i_sel;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic [3:0]  d_sel;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        addr_ok;
    logic        data_ok;
    logic [31:0] dout;
    logic        bus_req;
    logic [31:0] addr;
    logic [31:0] din;
    logic        wr;
    logic [3:0]  ben;

    modport slave (
        input  i_req, i_addr, i_wdata, i_we, i_sel,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_addr, d_wdata, d_we, d_sel,
        output d_gnt, d_rvalid, d_rdata,
        input  addr_ok, data_ok, dout,
        output bus_req, addr, din, wr, ben
    );

    modport master (
        output i_req, i_addr, i_wdata, i_we, i_sel,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_addr, d_wdata, d_we, d_sel,
        input  d_gnt, d_rvalid, d_rdata,
        output addr_ok, data_ok, dout,
        input  bus_req, addr, din, wr, ben
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: shares one addr_ok/data_ok memory port between the inst and data masters, one transaction at a time.
// Ports: clk, rst (sync, active-high), bus (ahb_bus_arbiter_if.slave). Macro ARB_ROUND_ROBIN_EN selects round-robin, else data wins.
module ahb_bus_arbiter (
    input  logic                clk,
    input  logic                rst,
    ahb_bus_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_owner_q;
    logic        bus_req_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic        wr_q;
    logic [3:0]  ben_q;

    logic        is_idle;
    logic        pick_d;
    logic        accept;
    logic        i_done;
    logic        d_done;

    // The unused encoding behaves as IDLE.
    assign is_idle = (state_q != I_BUSY) && (state_q != D_BUSY);

`ifdef ARB_ROUND_ROBIN_EN
    // On contention, favour whoever did not own the bus last.
    assign pick_d = bus.d_req && (!bus.i_req || !last_owner_q);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_q;
    assign pick_d = bus.d_req;
`endif

    assign accept = !rst && is_idle && bus.addr_ok
                  && (bus.i_req || bus.d_req);

    assign bus.i_gnt = accept && !pick_d;
    assign bus.d_gnt = accept && pick_d;

    assign i_done = !rst && (state_q == I_BUSY) && bus.data_ok;
    assign d_done = !rst && (state_q == D_BUSY) && bus.data_ok;

    // Writes return zero read data.
    assign bus.i_rvalid = i_done;
    assign bus.d_rvalid = d_done;
    assign bus.i_rdata  = (i_done && !wr_q) ? bus.dout : 32'd0;
    assign bus.d_rdata  = (d_done && !wr_q) ? bus.dout : 32'd0;

    assign bus.bus_req = bus_req_q;
    assign bus.addr    = addr_q;
    assign bus.din     = din_q;
    assign bus.wr      = wr_q;
    assign bus.ben     = ben_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b0;
            bus_req_q    <= 1'b0;
            addr_q       <= 32'd0;
            din_q        <= 32'd0;
            wr_q         <= 1'b0;
            ben_q        <= 4'd0;
        end else begin
            case (state_q)
                I_BUSY, D_BUSY: begin
                    if (bus.data_ok) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        addr_q    <= 32'd0;
                        din_q     <= 32'd0;
                        wr_q      <= 1'b0;
                        ben_q     <= 4'd0;
                    end
                end
                default: begin
                    if (accept) begin
                        bus_req_q <= 1'b1;
                        if (pick_d) begin
                            state_q      <= D_BUSY;
                            last_owner_q <= 1'b1;
                            addr_q       <= bus.d_addr;
                            din_q        <= bus.d_wdata;
                            wr_q         <= bus.d_we;
                            ben_q        <= bus.d_sel;
                        end else begin
                            state_q      <= I_BUSY;
                            last_owner_q <= 1'b0;
                            addr_q       <= bus.i_addr;
                            din_q        <= bus.i_wdata;
                            wr_q         <= bus.i_we;
                            ben_q        <= bus.i_sel;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed stimulus with a scoreboard of expected grants and completions.
// A negedge monitor pops and compares whenever the arbiter presents a gnt, bus command or rvalid.
module tb_ahb_bus_arbiter;

    typedef struct {
        bit          own_d;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] din;
        logic        wr;
        logic [3:0]  ben;
    } exp_t;

    logic clk;
    logic rst;
    ahb_bus_arbiter_if bus ();

    ahb_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks;
    int   failures;
    bit   gnt_q [$];
    exp_t exp_q [$];
    bit   own_tab [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            bit   g;
            if (bus.i_gnt || bus.d_gnt) begin
                chk("gnt_onehot", {31'd0, bus.i_gnt && bus.d_gnt}, 32'd0);
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", {31'd0, bus.d_gnt}, 32'hFFFF_FFFF);
                end else begin
                    g = gnt_q.pop_front();
                    chk("gnt_owner", {31'd0, bus.d_gnt}, {31'd0, g});
                end
            end
            if (bus.bus_req) begin
                if (exp_q.size() == 0) begin
                    chk("bus_unexpected", bus.addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[0];
                    chk("bus_addr", bus.addr, e.addr);
                    chk("bus_din", bus.din, e.din);
                    chk("bus_wr", {31'd0, bus.wr}, {31'd0, e.wr});
                    chk("bus_ben", {28'd0, bus.ben}, {28'd0, e.ben});
                end
            end else begin
                chk("idle_addr", bus.addr, 32'd0);
                chk("idle_din", bus.din, 32'd0);
                chk("idle_wr_ben", {27'd0, bus.wr, bus.ben}, 32'd0);
            end
            if (!bus.i_rvalid) chk("i_rdata_zero", bus.i_rdata, 32'd0);
            if (!bus.d_rvalid) chk("d_rdata_zero", bus.d_rdata, 32'd0);
            if (bus.i_rvalid || bus.d_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", {31'd0, bus.d_rvalid}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rv_owner", {31'd0, bus.d_rvalid}, {31'd0, e.own_d});
                    chk("rv_other", {31'd0, e.own_d ? bus.i_rvalid : bus.d_rvalid}, 32'd0);
                    chk("rdata", e.own_d ? bus.d_rdata : bus.i_rdata, e.rdata);
                end
            end
        end
    end

    task automatic push_exp(input bit d, input logic [31:0] a, wd,
                            input logic we, input logic [3:0] sel,
                            input logic [31:0] rd);
        exp_t e;
        e.own_d = d;
        e.rdata = we ? 32'd0 : rd;
        e.addr  = a;
        e.din   = wd;
        e.wr    = we;
        e.ben   = sel;
        gnt_q.push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic drive_cmd(input bit d, input logic [31:0] a, wd,
                             input logic we, input logic [3:0] sel);
        if (d) begin
            bus.d_req = 1'b1; bus.d_addr = a; bus.d_wdata = wd;
            bus.d_we = we; bus.d_sel = sel;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = a; bus.i_wdata = wd;
            bus.i_we = we; bus.i_sel = sel;
        end
    endtask

    task automatic xact(input bit d, input logic [31:0] a, wd,
                        input logic we, input logic [3:0] sel,
                        input logic [31:0] rd, input int lat);
        drive_cmd(d, a, wd, we, sel);
        bus.addr_ok = 1'b1;
        push_exp(d, a, wd, we, sel, rd);
        cyc();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.addr_ok = 1'b0;
        repeat (lat) cyc();
        bus.data_ok = 1'b1;
        bus.dout = rd;
        cyc();
        bus.data_ok = 1'b0;
        bus.dout = 32'd0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bus_req"}, {31'd0, bus.bus_req}, 32'd0);
        chk({tag, "_addr"}, bus.addr, 32'd0);
        chk({tag, "_din"}, bus.din, 32'd0);
        chk({tag, "_wr_ben"}, {27'd0, bus.wr, bus.ben}, 32'd0);
        chk({tag, "_gnt"}, {30'd0, bus.i_gnt, bus.d_gnt}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        chk({tag, "_rdata"}, bus.i_rdata | bus.d_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
`ifdef ARB_ROUND_ROBIN_EN
        own_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        own_tab = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.i_wdata = 0; bus.i_we = 0; bus.i_sel = 0;
        bus.d_req = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_we = 0; bus.d_sel = 0;
        bus.addr_ok = 0; bus.data_ok = 0; bus.dout = 0;
        repeat (3) cyc();
        @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk_quiet("post_reset");
        cyc();

        // Contention straight after reset: last_owner is inst
        for (int k = 0; k < 4; k++) begin
            drive_cmd(1'b0, 32'h0000_0100, 32'd0, 1'b0, 4'hF);
            drive_cmd(1'b1, 32'h0000_0200, 32'd0, 1'b0, 4'hF);
            bus.addr_ok = 1'b1;
            bus.data_ok = 1'b0;
            push_exp(own_tab[k], own_tab[k] ? 32'h0000_0200 : 32'h0000_0100,
                     32'd0, 1'b0, 4'hF, 32'hC0DE_0000 + k);
            cyc();
            bus.data_ok = 1'b1;
            bus.dout = 32'hC0DE_0000 + k;
            cyc();
        end
        bus.i_req = 0; bus.d_req = 0; bus.addr_ok = 0;
        bus.data_ok = 0; bus.dout = 0;
        cyc();

        // Single instruction read
        xact(1'b0, 32'h1FC0_0000, 32'd0, 1'b0, 4'hF, 32'h2408_0001, 0);
        // Data write, read data must come back zero
        xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 4'b0011, 32'h1234_5678, 0);

        // Backpressure
        drive_cmd(1'b0, 32'h0000_0400, 32'd0, 1'b0, 4'hF);
        bus.addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_no_gnt", {30'd0, bus.i_gnt, bus.d_gnt}, 32'd0);
            chk("bp_no_bus_req", {31'd0, bus.bus_req}, 32'd0);
            cyc();
        end
        bus.i_req = 0;
        xact(1'b0, 32'h0000_0400, 32'd0, 1'b0, 4'hF, 32'hA5A5_0400, 1);

        // Hold in BUSY with a new data request pending
        drive_cmd(1'b1, 32'h8000_0100, 32'h0BAD_F00D, 1'b1, 4'b1100);
        bus.addr_ok = 1'b1;
        push_exp(1'b1, 32'h8000_0100, 32'h0BAD_F00D, 1'b1, 4'b1100, 32'h77);
        cyc();
        drive_cmd(1'b1, 32'h9999_0000, 32'h1, 1'b0, 4'hF);
        repeat (5) begin
            @(negedge clk);
            chk("hold_no_gnt", {31'd0, bus.d_gnt}, 32'd0);
            cyc();
        end
        bus.d_req = 1'b0;
        bus.data_ok = 1'b1;
        bus.dout = 32'h77;
        cyc();
        bus.data_ok = 1'b0;
        bus.addr_ok = 1'b0;
        bus.dout = 32'd0;

        // Reset while busy, coinciding with data_ok
        drive_cmd(1'b0, 32'h0000_0040, 32'd0, 1'b0, 4'hF);
        bus.addr_ok = 1'b1;
        push_exp(1'b0, 32'h0000_0040, 32'd0, 1'b0, 4'hF, 32'd0);
        cyc();
        bus.i_req = 1'b0;
        bus.addr_ok = 1'b0;
        rst = 1'b1;
        bus.data_ok = 1'b1;
        bus.dout = 32'h5555_5555;
        exp_q.delete();
        @(negedge clk);
        chk("rst_busy_rvalid", {30'd0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        chk("rst_busy_rdata", bus.i_rdata, 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("after_rst");
        cyc();
        bus.data_ok = 1'b0;
        bus.dout = 32'd0;

        // Recovery after abandoned transaction
        xact(1'b1, 32'h0000_0800, 32'd0, 1'b0, 4'b0001, 32'h0000_00AB, 2);
        cyc();

        chk("gnt_q_drained", gnt_q.size(), 32'd0);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
